// File: rtl/cap_bank_ctrl.sv
// Slew-limited DCO capacitor-bank controller: ramps a thermometer-coded cell matrix toward a requested count.
// Optional macro CAP_BANK_SAT_EN: clamp out-of-range requests to NCELL and report them on a sticky sat flag.
module cap_bank_ctrl #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int MAX_STEP = 4,
    parameter int RST_CODE = 0,
    localparam int NCELL   = ROWS * COLS,
    localparam int CW      = $clog2(NCELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CW-1:0]    tune_in,
    input  logic             tune_valid,
    output logic             tune_ready,
    output logic [NCELL-1:0] sel_out,
    output logic [CW-1:0]    code_out,
    output logic             busy
`ifdef CAP_BANK_SAT_EN
   ,output logic             sat
`endif
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [CW-1:0] NCELL_C    = CW'(NCELL);
    localparam logic [CW-1:0] RST_C      = CW'(RST_CODE);
    localparam logic [CW:0]   MAX_STEP_C = (CW + 1)'(MAX_STEP);

    state_t        state;
    logic [CW-1:0] target;
    logic [CW:0]   diff;
    logic [CW:0]   mag;
    logic [CW-1:0] step;
    logic [CW-1:0] ramp_code;
    logic [CW-1:0] accept_code;
    logic          accept;
    logic          accept_ok;
    logic          in_range;

    // Cells are numbered row-major, so the r<R / partial-row rule collapses to index < code.
    function automatic logic [NCELL-1:0] therm(input logic [CW-1:0] c);
        return ~({NCELL{1'b1}} << c);
    endfunction

    assign tune_ready = en & ~rst & (state == IDLE);
    assign busy       = (state == RAMP);
    assign accept     = tune_valid & tune_ready;
    assign in_range   = (tune_in <= NCELL_C);

`ifdef CAP_BANK_SAT_EN
    assign accept_code = in_range ? tune_in : NCELL_C;
    assign accept_ok   = accept;
`else
    assign accept_code = tune_in;
    assign accept_ok   = accept & in_range;
`endif

    // One extra bit makes the difference signed, so the step never overshoots or wraps.
    always_comb begin
        diff      = {1'b0, target} - {1'b0, code_out};
        mag       = diff[CW] ? -diff : diff;
        step      = (mag > MAX_STEP_C) ? MAX_STEP_C[CW-1:0] : mag[CW-1:0];
        ramp_code = diff[CW] ? (code_out - step) : (code_out + step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code_out <= RST_C;
            sel_out  <= therm(RST_C);
            target   <= RST_C;
`ifdef CAP_BANK_SAT_EN
            sat      <= 1'b0;
`endif
        end else if (en) begin
            if (state == IDLE) begin
                if (accept_ok) begin
                    target <= accept_code;
                    if (accept_code != code_out) begin
                        state <= RAMP;
                    end
                end
`ifdef CAP_BANK_SAT_EN
                if (accept && !in_range) begin
                    sat <= 1'b1;
                end
`endif
            end else begin
                code_out <= ramp_code;
                sel_out  <= therm(ramp_code);
                if (ramp_code == target) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule
